// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues variable-latency instruction reads,
// loads IF/ID, redirects on ID-stage mispredicts and keeps fetch/mispredict counters.
module fetch_pc_unit #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [WORD_SIZE-1:0] PC,
  input  logic [WORD_SIZE-1:0] predicted_nextPC,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  input  logic                 stall,
  input  logic                 resolve_valid,
  input  logic [WORD_SIZE-1:0] resolved_PC,
  output logic [WORD_SIZE-1:0] IF_ID_PC,
  output logic [WORD_SIZE-1:0] IF_ID_inst,
  output logic [WORD_SIZE-1:0] IF_ID_pred_PC,
  output logic                 IF_ID_valid,
  output logic                 mispredict,
  output logic [15:0]          fetch_count,
  output logic [15:0]          mispredict_count
);

  typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] buf_pc;
  logic [WORD_SIZE-1:0] buf_inst;
  logic [WORD_SIZE-1:0] buf_pred;

  // A stalled ID stage cannot act on its resolution, so stall masks the redirect.
  assign mispredict = resolve_valid & IF_ID_valid & ~stall & (resolved_PC != IF_ID_pred_PC);
  assign i_readM    = (state == FETCH);
  assign i_address  = PC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= FETCH;
      PC               <= RESET_PC;
      IF_ID_PC         <= '0;
      IF_ID_inst       <= '0;
      IF_ID_pred_PC    <= '0;
      IF_ID_valid      <= 1'b0;
      buf_pc           <= '0;
      buf_inst         <= '0;
      buf_pred         <= '0;
      fetch_count      <= '0;
      mispredict_count <= '0;
    end else if (mispredict) begin
      PC          <= resolved_PC;
      IF_ID_valid <= 1'b0;
      state       <= REDIRECT;
      if (mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end else begin
      case (state)
        FETCH: begin
          if (i_ready && !stall) begin
            IF_ID_PC      <= PC;
            IF_ID_inst    <= i_data;
            IF_ID_pred_PC <= predicted_nextPC;
            IF_ID_valid   <= 1'b1;
            PC            <= predicted_nextPC;
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
          end else if (i_ready) begin
            buf_pc   <= PC;
            buf_inst <= i_data;
            buf_pred <= predicted_nextPC;
            state    <= HOLD;
          end else if (!stall) begin
            IF_ID_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            IF_ID_PC      <= buf_pc;
            IF_ID_inst    <= buf_inst;
            IF_ID_pred_PC <= buf_pred;
            IF_ID_valid   <= 1'b1;
            PC            <= buf_pred;
            state         <= FETCH;
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
          end
        end
        // One request-free cycle lets memory drop the read aimed at the old PC.
        REDIRECT: state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: hand-computed vector table, reset corner sequence and
// randomized traffic checked against a queue-based model of the fetch stage.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] PC, predicted_nextPC, i_address, i_data, resolved_PC;
  logic [15:0] IF_ID_PC, IF_ID_inst, IF_ID_pred_PC, fetch_count, mispredict_count;
  logic        i_readM, i_ready, stall, resolve_valid, IF_ID_valid, mispredict;
  logic [15:0] pred_step = 16'd1;

  fetch_pc_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .PC(PC), .predicted_nextPC(predicted_nextPC),
    .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .stall(stall), .resolve_valid(resolve_valid), .resolved_PC(resolved_PC),
    .IF_ID_PC(IF_ID_PC), .IF_ID_inst(IF_ID_inst), .IF_ID_pred_PC(IF_ID_pred_PC),
    .IF_ID_valid(IF_ID_valid), .mispredict(mispredict), .fetch_count(fetch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return (a * 16'd3) ^ 16'hC3A5;
  endfunction

  // Predictor and memory stand-ins
  assign predicted_nextPC = PC + pred_step;
  assign i_data = i_ready ? inst_of(i_address) : 16'hDEAD;

  typedef struct packed {logic [15:0] pc, inst, pred;} entry_t;
  typedef struct {
    logic stall, ready, rv; logic [15:0] rpc;
    logic exp_readm; logic [15:0] exp_addr, exp_if_pc; logic exp_valid;
    logic [15:0] exp_fcnt; logic exp_mis; logic [15:0] exp_mcnt;
  } vec_t;

  entry_t      held[$];
  vec_t        tbl[$];
  logic [15:0] m_pc, m_if_pc, m_if_inst, m_if_pred, m_fcnt, m_mcnt;
  logic        m_valid, m_gap;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic model_mis();
    return resolve_valid && m_valid && !stall && (resolved_PC != m_if_pred);
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_if_pc = '0; m_if_inst = '0; m_if_pred = '0;
    m_valid = 1'b0; m_fcnt = '0; m_mcnt = '0; m_gap = 1'b0;
    held.delete();
  endtask

  task automatic check_model();
    check_output("PC", PC, m_pc);
    check_output("i_address", i_address, m_pc);
    check_bit("i_readM", i_readM, (held.size() == 0) && !m_gap);
    check_output("IF_ID_PC", IF_ID_PC, m_if_pc);
    check_output("IF_ID_inst", IF_ID_inst, m_if_inst);
    check_output("IF_ID_pred_PC", IF_ID_pred_PC, m_if_pred);
    check_bit("IF_ID_valid", IF_ID_valid, m_valid);
    check_bit("mispredict", mispredict, model_mis());
    check_output("fetch_count", fetch_count, m_fcnt);
    check_output("mispredict_count", mispredict_count, m_mcnt);
  endtask

  // One clock of fetch behaviour: redirect wins, then the idle gap, then a
  // buffered word, then whatever memory returns this cycle.
  task automatic model_advance();
    logic [15:0] pred;
    entry_t      e;
    pred = m_pc + pred_step;
    if (model_mis()) begin
      m_pc = resolved_PC; m_valid = 1'b0; held.delete(); m_gap = 1'b1;
      if (m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (held.size() != 0) begin
      if (!stall) begin
        e = held.pop_front();
        m_if_pc = e.pc; m_if_inst = e.inst; m_if_pred = e.pred; m_valid = 1'b1;
        m_pc = e.pred;
        if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
      end
    end else if (i_ready && !stall) begin
      m_if_pc = m_pc; m_if_inst = inst_of(m_pc); m_if_pred = pred; m_valid = 1'b1;
      m_pc = pred;
      if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
    end else if (i_ready) begin
      e.pc = m_pc; e.inst = inst_of(m_pc); e.pred = pred;
      held.push_back(e);
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic r, input logic rv, input logic [15:0] rpc);
    stall = s; i_ready = r; resolve_valid = rv; resolved_PC = rpc;
    #1;
    check_model();
  endtask

  task automatic next_cycle();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_row(input logic s, input logic r, input logic rv, input logic [15:0] rpc,
                         input logic rdm, input logic [15:0] addr, input logic [15:0] ifpc,
                         input logic v, input logic [15:0] fc, input logic mis, input logic [15:0] mc);
    vec_t t;
    t.stall = s; t.ready = r; t.rv = rv; t.rpc = rpc;
    t.exp_readm = rdm; t.exp_addr = addr; t.exp_if_pc = ifpc; t.exp_valid = v;
    t.exp_fcnt = fc; t.exp_mis = mis; t.exp_mcnt = mc;
    tbl.push_back(t);
  endtask

  initial begin
    // stall ready rv rpc | readM addr IF_ID_PC valid fetch_cnt mispredict mis_cnt
    add_row(0, 1, 0,  0,  1,  0,  0, 0,  0, 0, 0);
    add_row(0, 1, 0,  0,  1,  1,  0, 1,  1, 0, 0);
    add_row(0, 1, 0,  0,  1,  2,  1, 1,  2, 0, 0);
    add_row(0, 1, 0,  0,  1,  3,  2, 1,  3, 0, 0);
    add_row(0, 0, 0,  0,  1,  4,  3, 1,  4, 0, 0);
    add_row(0, 0, 0,  0,  1,  4,  3, 0,  4, 0, 0);
    add_row(0, 0, 0,  0,  1,  4,  3, 0,  4, 0, 0);
    add_row(0, 1, 0,  0,  1,  4,  3, 0,  4, 0, 0);
    add_row(1, 0, 0,  0,  1,  5,  4, 1,  5, 0, 0);
    add_row(1, 1, 0,  0,  1,  5,  4, 1,  5, 0, 0);
    add_row(1, 0, 0,  0,  0,  5,  4, 1,  5, 0, 0);
    add_row(1, 0, 0,  0,  0,  5,  4, 1,  5, 0, 0);
    add_row(0, 0, 0,  0,  0,  5,  4, 1,  5, 0, 0);
    add_row(0, 0, 0,  0,  1,  6,  5, 1,  6, 0, 0);
    add_row(0, 1, 0,  0,  1,  6,  5, 0,  6, 0, 0);
    add_row(0, 1, 0,  0,  1,  7,  6, 1,  7, 0, 0);
    add_row(0, 1, 1, 20,  1,  8,  7, 1,  8, 1, 0);
    add_row(0, 1, 0,  0,  0, 20,  7, 0,  8, 0, 1);
    add_row(0, 1, 0,  0,  1, 20,  7, 0,  8, 0, 1);
    add_row(0, 0, 1, 21,  1, 21, 20, 1,  9, 0, 1);
    add_row(0, 1, 0,  0,  1, 21, 20, 0,  9, 0, 1);
    add_row(1, 0, 1, 99,  1, 22, 21, 1, 10, 0, 1);
    add_row(0, 0, 0,  0,  1, 22, 21, 1, 10, 0, 1);

    stall = 0; i_ready = 0; resolve_valid = 0; resolved_PC = '0;
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_model();
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i].stall, tbl[i].ready, tbl[i].rv, tbl[i].rpc);
      check_bit($sformatf("row%0d i_readM", i), i_readM, tbl[i].exp_readm);
      check_output($sformatf("row%0d i_address", i), i_address, tbl[i].exp_addr);
      check_output($sformatf("row%0d IF_ID_PC", i), IF_ID_PC, tbl[i].exp_if_pc);
      check_bit($sformatf("row%0d IF_ID_valid", i), IF_ID_valid, tbl[i].exp_valid);
      check_output($sformatf("row%0d fetch_count", i), fetch_count, tbl[i].exp_fcnt);
      check_bit($sformatf("row%0d mispredict", i), mispredict, tbl[i].exp_mis);
      check_output($sformatf("row%0d mispredict_count", i), mispredict_count, tbl[i].exp_mcnt);
      next_cycle();
    end

    // Reset asserted in the middle of a fetch at PC=9 with non-zero counters
    reset_n = 1'b0; model_reset(); #1;
    check_model();
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(0, 1, 0, 16'd0);
      next_cycle();
    end
    apply_stimulus(0, 1, 1, 16'd9);
    check_bit("redirect to 9", mispredict, 1'b1);
    next_cycle();
    apply_stimulus(0, 1, 0, 16'd0);
    next_cycle();
    apply_stimulus(0, 0, 0, 16'd0);
    check_output("pre-reset PC", PC, 16'd9);
    check_bit("pre-reset i_readM", i_readM, 1'b1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_output("async reset PC", PC, 16'd0);
    check_bit("async reset IF_ID_valid", IF_ID_valid, 1'b0);
    check_output("async reset fetch_count", fetch_count, 16'd0);
    check_output("async reset mispredict_count", mispredict_count, 16'd0);
    @(negedge clk); reset_n = 1'b1;
    apply_stimulus(0, 1, 0, 16'd0);
    check_bit("post-reset i_readM", i_readM, 1'b1);
    check_output("post-reset i_address", i_address, 16'd0);
    next_cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      pred_step = ($urandom % 5 == 0) ? 16'($urandom) : 16'd1;
      apply_stimulus(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                     ($urandom % 2 == 0) ? m_if_pred : 16'($urandom));
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
